// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared fetch-stage types and constants
package if_fetch_unit_pkg;
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        PRESENT,
        DRAIN
    } fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/if_fetch_unit_timeout_ctr.sv
// fetch_timeout_ctr: counts cycles spent waiting on a memory response
module fetch_timeout_ctr #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYC);
    logic [W-1:0] cnt;
    // restart on acceptance; wrap at expiry so a held DRAIN keeps timing out cleanly
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= expired ? '0 : cnt + 1'b1;
    assign expired = cnt == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and instruction-memory fetch FSM feeding the IF/ID register
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze_in,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        fetch_stall,
    output logic        fetch_error
);
    fetch_state_t state;
    logic [31:0] pc, buffer;
    logic expired;
    logic accept;
    assign accept = state == REQ && imem_ready;
    fetch_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk(clk),
        .rst(rst),
        .clear(accept),
        .enable(state == WAIT || state == DRAIN),
        .expired(expired)
    );
    // fetch FSM: branch redirects first, then response capture, then timeout/advance
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            pc <= BOOT_ADDR;
            buffer <= NOP_INSTR;
            fetch_error <= 1'b0;
        end else begin
            if (branch_taken) pc <= branch_addr;
            case (state)
                IDLE: state <= REQ;
                REQ:
                    if (branch_taken) state <= imem_ready ? DRAIN : REQ;
                    else if (imem_ready) state <= WAIT;
                WAIT:
                    if (branch_taken) state <= imem_rvalid ? REQ : DRAIN;
                    else if (imem_rvalid) begin
                        buffer <= imem_rdata;
                        state <= PRESENT;
                    end else if (expired) begin
                        fetch_error <= 1'b1;
                        state <= REQ;
                    end
                PRESENT:
                    if (branch_taken) state <= REQ;
                    else if (!freeze_in) begin
                        pc <= pc + PC_INC;
                        state <= REQ;
                    end
                DRAIN:
                    if (imem_rvalid) state <= REQ;
                    else if (expired && !branch_taken) begin
                        fetch_error <= 1'b1;
                        state <= REQ;
                    end
                default: state <= IDLE;
            endcase
        end
    assign imem_req = state == REQ;
    assign imem_addr = pc;
    assign pc_out = pc + PC_INC;
    assign fetch_stall = state != PRESENT;
    assign instruction_out = state == PRESENT ? buffer : NOP_INSTR;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed vector table plus hand sequences for timeout, reset and wrap
module tb_if_fetch_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic freeze_in = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] branch_addr = '0, imem_rdata = '0;
    logic imem_req, fetch_stall, fetch_error;
    logic [31:0] imem_addr, pc_out, instruction_out;
    int checks = 0, errors = 0;
    localparam logic [31:0] A = 32'hA5A5_0000;

    typedef struct packed {
        logic        freeze, branch;
        logic [31:0] baddr;
        logic        ready, rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr, pco, instr;
        logic        stall;
    } vec_t;
    vec_t tbl [35];

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .freeze_in(freeze_in), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .instruction_out(instruction_out), .fetch_stall(fetch_stall),
        .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic fr, input logic br, input logic [31:0] ba,
                                input logic rd, input logic rv, input logic [31:0] dat,
                                input logic rq, input logic [31:0] ad, input logic [31:0] pco,
                                input logic [31:0] ins, input logic st);
        vec_t v;
        v.freeze = fr; v.branch = br; v.baddr = ba; v.ready = rd; v.rvalid = rv; v.rdata = dat;
        v.req = rq; v.addr = ad; v.pco = pco; v.instr = ins; v.stall = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic rq, input logic [31:0] ad,
                           input logic [31:0] pco, input logic [31:0] ins, input logic st);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, rq});
        chk({tag, ".addr"}, imem_addr, ad);
        chk({tag, ".pc_out"}, pc_out, pco);
        chk({tag, ".instr"}, instruction_out, ins);
        chk({tag, ".stall"}, {31'd0, fetch_stall}, {31'd0, st});
    endtask

    initial begin
        //            fr br baddr   rdy rv rdata          req addr     pc_out   instr        stall
        tbl[0]  = mk(0, 0, 0,       1, 0, 0,             0, 0,       4,       0,           1);
        tbl[1]  = mk(0, 0, 0,       1, 0, 0,             1, 0,       4,       0,           1);
        tbl[2]  = mk(0, 0, 0,       1, 1, A,             0, 0,       4,       0,           1);
        tbl[3]  = mk(0, 0, 0,       1, 0, 0,             0, 0,       4,       A,           0);
        tbl[4]  = mk(0, 0, 0,       1, 0, 0,             1, 4,       8,       0,           1);
        tbl[5]  = mk(0, 0, 0,       1, 1, A | 32'h4,     0, 4,       8,       0,           1);
        tbl[6]  = mk(0, 0, 0,       1, 0, 0,             0, 4,       8,       A | 32'h4,   0);
        tbl[7]  = mk(0, 0, 0,       1, 0, 0,             1, 8,       12,      0,           1);
        tbl[8]  = mk(0, 0, 0,       1, 1, A | 32'h8,     0, 8,       12,      0,           1);
        for (int i = 9; i < 14; i++)
            tbl[i] = mk(1, 0, 0,    1, 0, 0,             0, 8,       12,      A | 32'h8,   0);
        tbl[14] = mk(0, 0, 0,       1, 0, 0,             0, 8,       12,      A | 32'h8,   0);
        tbl[15] = mk(0, 0, 0,       1, 0, 0,             1, 12,      16,      0,           1);
        tbl[16] = mk(0, 0, 0,       1, 1, A | 32'hC,     0, 12,      16,      0,           1);
        tbl[17] = mk(0, 0, 0,       1, 0, 0,             0, 12,      16,      A | 32'hC,   0);
        tbl[18] = mk(0, 0, 0,       1, 0, 0,             1, 16,      20,      0,           1);
        tbl[19] = mk(0, 1, 32'h100, 1, 0, 0,             0, 16,      20,      0,           1);
        tbl[20] = mk(0, 0, 0,       1, 0, 0,             0, 32'h100, 32'h104, 0,           1);
        tbl[21] = mk(0, 0, 0,       1, 0, 0,             0, 32'h100, 32'h104, 0,           1);
        tbl[22] = mk(0, 0, 0,       1, 1, 32'hDEADBEEF,  0, 32'h100, 32'h104, 0,           1);
        tbl[23] = mk(0, 0, 0,       1, 0, 0,             1, 32'h100, 32'h104, 0,           1);
        tbl[24] = mk(0, 1, 32'h200, 1, 1, A | 32'h100,   0, 32'h100, 32'h104, 0,           1);
        for (int i = 25; i < 29; i++)
            tbl[i] = mk(0, 0, 0,    0, 0, 0,             1, 32'h200, 32'h204, 0,           1);
        tbl[29] = mk(0, 0, 0,       1, 0, 0,             1, 32'h200, 32'h204, 0,           1);
        tbl[30] = mk(0, 0, 0,       1, 1, A | 32'h200,   0, 32'h200, 32'h204, 0,           1);
        tbl[31] = mk(0, 0, 0,       1, 0, 0,             0, 32'h200, 32'h204, A | 32'h200, 0);
        tbl[32] = mk(0, 1, 32'h20,  1, 0, 0,             1, 32'h204, 32'h208, 0,           1);
        tbl[33] = mk(0, 0, 0,       1, 1, 32'h1111_2222, 0, 32'h20,  32'h24,  0,           1);
        tbl[34] = mk(0, 0, 0,       1, 0, 0,             1, 32'h20,  32'h24,  0,           1);

        repeat (2) @(negedge clk);
        chk_out("reset", 0, 0, 4, 0, 1);
        chk("reset.err", {31'd0, fetch_error}, 0);
        rst = 1'b0;
        for (int i = 0; i < 35; i++) begin
            freeze_in = tbl[i].freeze; branch_taken = tbl[i].branch; branch_addr = tbl[i].baddr;
            imem_ready = tbl[i].ready; imem_rvalid = tbl[i].rvalid; imem_rdata = tbl[i].rdata;
            chk_out($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].pco, tbl[i].instr,
                    tbl[i].stall);
            chk($sformatf("vec%0d.err", i), {31'd0, fetch_error}, 0);
            @(negedge clk);
        end
        freeze_in = 0; branch_taken = 0; imem_rvalid = 0; imem_ready = 1;
        for (int k = 0; k < 64; k++) begin
            chk($sformatf("wait%0d.req_err", k), {30'd0, imem_req, fetch_error}, 0);
            @(negedge clk);
        end
        chk_out("timeout", 1, 32'h20, 32'h24, 0, 1);
        chk("timeout.err", {31'd0, fetch_error}, 1);
        @(negedge clk);
        imem_rvalid = 1; imem_rdata = A | 32'h20;
        @(negedge clk);
        imem_rvalid = 0;
        chk_out("retry", 0, 32'h20, 32'h24, A | 32'h20, 0);
        chk("sticky.err", {31'd0, fetch_error}, 1);
        @(negedge clk);
        chk_out("next", 1, 32'h24, 32'h28, 0, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
        #1 chk_out("midrst", 0, 0, 4, 0, 1);
        chk("midrst.err", {31'd0, fetch_error}, 0);
        @(negedge clk);
        rst = 1'b0;
        branch_taken = 1; branch_addr = 32'hFFFF_FFFC;
        chk_out("idle", 0, 0, 4, 0, 1);
        @(negedge clk);
        branch_taken = 0; imem_rvalid = 0;
        chk_out("wrap_req", 1, 32'hFFFF_FFFC, 0, 0, 1);
        @(negedge clk);
        imem_rvalid = 1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_rvalid = 0;
        chk_out("wrap_pres", 0, 32'hFFFF_FFFC, 0, 32'h1234_5678, 0);
        @(negedge clk);
        chk_out("wrap_next", 1, 0, 4, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
